maxpool_stream: RTL
===================

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 Parameter WIDTH, 16, sample width in bits (signed two's complement).
REQ-002 Parameter POOL, 2, pooling window length in samples (2..8).
REQ-003 Parameter LENY, 32, input samples per frame, i.e. convolution outputs per frame (LENX-LENF+1).
REQ-004 Port clk  input  1  single clock; all state updates on posedge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port s_data_in_x  input  WIDTH  signed input sample from upstream convolution stage.
REQ-007 Port s_valid_x  input  1  upstream sample valid.
REQ-008 Port s_ready_x  output  1  block can accept a sample this cycle.
REQ-009 Port m_data_out_y  output  WIDTH  signed pooled result.
REQ-010 Port m_valid_y  output  1  pooled result valid.
REQ-011 Port m_ready_y  input  1  downstream accepts the result.
REQ-012 Port m_last_y  output  1  high with m_valid_y on the last pooled result of a frame.

Function
REQ-013 A sample transfers when s_valid_x && s_ready_x on a posedge; a result transfers when m_valid_y && m_ready_y on a posedge.
REQ-014 s_ready_x SHALL be combinational: !m_valid_y || m_ready_y; it SHALL NOT depend on s_valid_x.
REQ-015 Counters: win_cnt (0..POOL-1) is the position in the window; pos_cnt (0..LENY-1) is the position in the frame; both advance only on an accepted sample.
REQ-016 When win_cnt==0, the accepted sample loads the running max; otherwise running max = signed max(running max, sample).
REQ-017 A window closes on an accepted sample when win_cnt==POOL-1 or pos_cnt==LENY-1; at a close, win_cnt returns to 0.
REQ-018 Partial window: when LENY is not divisible by POOL, the final window closes at pos_cnt==LENY-1 with fewer than POOL samples and emits its max.
REQ-019 At a window close, signed max(running max, sample) SHALL load the output register, with m_valid_y high the next cycle (latency 1 cycle from the closing sample).
REQ-020 m_last_y SHALL be registered alongside the result and be high only when the closing sample had pos_cnt==LENY-1; pos_cnt then wraps to 0 and the next frame starts with no idle cycle.
REQ-021 Results per frame SHALL be ceil(LENY/POOL).
REQ-022 While m_valid_y && !m_ready_y, m_data_out_y and m_last_y SHALL hold stable and no sample is accepted.
REQ-023 Simultaneous output drain and window close: the new result loads in the same cycle and m_valid_y stays high; non-closing samples accepted while draining clear m_valid_y.
REQ-024 Ties keep the running max value (values are equal, so the result is unaffected); the comparison SHALL be signed, so 16'h8000 < 16'h0000.

Reset
REQ-025 Reset SHALL clear asynchronously: m_valid_y=0, m_last_y=0, m_data_out_y=0, win_cnt=0, pos_cnt=0, running max=0; s_ready_x is then 1.
REQ-026 A reset asserted mid-frame SHALL discard the partial window and any unsent result; the first sample after release is sample 0 of a new frame.

Configuration
REQ-027 Macro MAXPOOL_RELU_EN: when defined, a result below 0 SHALL be replaced by 0 at the output register; when undefined, the signed max passes through unmodified.

Structure
REQ-028 Package maxpool_pkg SHALL hold the default WIDTH/POOL/LENY constants and typedef sample_t (logic signed [WIDTH-1:0]).
REQ-029 One sub-module, maxpool_out_stage, SHALL hold the output register, m_valid_y, m_last_y, the ReLU option and the s_ready_x logic; counters and running max remain in maxpool_stream.

Verification
REQ-030 POOL=2, LENY=32, m_ready_y=1, s_valid_x=1, inputs 5,-3,7,9,... -> outputs 5 then 9, each 1 cycle after the closing sample; 16 results per frame, m_last_y only on the 16th.
REQ-031 POOL=2, LENY=5, inputs 1,4,2,2,-6 -> outputs 4,2,-6 with m_last_y on -6 (without MAXPOOL_RELU_EN); -6 becomes 0 with the macro.
REQ-032 Backpressure: m_ready_y=0 for 10 cycles while a result is pending -> m_data_out_y stable, s_ready_x=0, no sample lost or duplicated once released; random s_valid_x/m_ready_y over 3 frames matches the golden model.
REQ-033 Signed extremes: inputs 16'h8000, 16'h7FFF -> output 16'h7FFF; inputs 16'h8000, 16'hFFFF -> output 16'hFFFF.
REQ-034 Reset asserted after sample 3 of a frame -> m_valid_y=0 immediately (asynchronously); the next frame produces correct window alignment from sample 0.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared constants and sample type for the streaming max-pool block.
package maxpool_pkg;

  localparam int WIDTH_D = 16;
  localparam int POOL_D  = 2;
  localparam int LENY_D  = 32;

  typedef logic signed [WIDTH_D-1:0] sample_t;

endpackage

// File: rtl/maxpool_out_stage.sv
// Output register, valid/last flags and upstream ready for max-pool.
// Build option MAXPOOL_RELU_EN clamps negative results to zero.
module maxpool_out_stage
  import maxpool_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic                    i_last,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    m_ready_y,
  output logic                    s_ready_x,
  output logic                    m_valid_y,
  output logic                    m_last_y,
  output logic signed [WIDTH-1:0] m_data_out_y
);

  logic signed [WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_last;
  logic signed [WIDTH-1:0] w_res;

`ifdef MAXPOOL_RELU_EN
  assign w_res = i_data[WIDTH-1] ? '0 : i_data;
`else
  assign w_res = i_data;
`endif

  assign s_ready_x = !r_valid || m_ready_y;

  // A close while draining reloads, so valid stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= w_res;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (r_valid && m_ready_y) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign m_valid_y    = r_valid;
  assign m_last_y     = r_last;
  assign m_data_out_y = r_data;

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool over frames of LENY samples, window POOL.
// Build option MAXPOOL_RELU_EN (see maxpool_out_stage).
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int POOL  = POOL_D,
  parameter int LENY  = LENY_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y,
  output logic                    m_last_y
);

  localparam int WW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int PW = (LENY > 1) ? $clog2(LENY) : 1;

  logic [WW-1:0]           r_win;
  logic [PW-1:0]           r_pos;
  logic signed [WIDTH-1:0] r_max;
  logic signed [WIDTH-1:0] w_max;
  logic                    w_ready;
  logic                    w_acc;
  logic                    w_plast;
  logic                    w_close;

  assign w_acc   = s_valid_x && w_ready;
  assign w_plast = (r_pos == PW'(LENY - 1));
  assign w_close = (r_win == WW'(POOL - 1)) || w_plast;

  // First sample of a window replaces the stale running max.
  always_comb begin
    w_max = s_data_in_x;
    if (r_win != '0 && r_max > s_data_in_x)
      w_max = r_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win <= '0;
      r_pos <= '0;
      r_max <= '0;
    end else if (w_acc) begin
      r_max <= w_max;
      r_win <= w_close ? '0 : r_win + 1'b1;
      r_pos <= w_plast ? '0 : r_pos + 1'b1;
    end
  end

  maxpool_out_stage #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_acc && w_close),
    .i_last      (w_plast),
    .i_data      (w_max),
    .m_ready_y   (m_ready_y),
    .s_ready_x   (w_ready),
    .m_valid_y   (m_valid_y),
    .m_last_y    (m_last_y),
    .m_data_out_y(m_data_out_y)
  );

  assign s_ready_x = w_ready;

endmodule
